// File: rtl/decompose_frame_ctrl.sv
// Frame sequencer for the first-level wavelet decomposition stage.
// Each frame runs PRIME (one zero block), then N upstream data blocks, then
// FLUSH_BLOCKS zero blocks. A tag pipe follows the stage latency and marks
// frame boundaries on the returning coefficient stream.
module decompose_frame_ctrl #(
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned NUM_LANES    = 16,
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned FLUSH_BLOCKS = 1,
  parameter int unsigned DEC_LAT      = 3
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  logic [CNT_W-1:0]                cfg_num_blocks,
  input  logic                            s_valid,
  output logic                            s_ready,
  input  logic [NUM_LANES*DATA_WIDTH-1:0] s_data,
  output logic                            dec_valid,
  output logic [NUM_LANES*DATA_WIDTH-1:0] dec_data,
  input  logic                            dec_dout_valid,
  output logic                            out_keep,
  output logic                            out_sop,
  output logic                            out_eop,
  output logic                            busy,
  output logic                            done,
  output logic                            err
);

  localparam int unsigned FW = (FLUSH_BLOCKS > 1) ? $clog2(FLUSH_BLOCKS) : 1;

  typedef enum logic [2:0] {
    IDLE,
    PRIME,
    DATA,
    FLUSH,
    DRAIN
  } state_t;

  typedef struct packed {
    logic valid;
    logic keep;
    logic sop;
    logic eop;
  } tag_t;

  state_t           state, state_nxt;
  logic [CNT_W-1:0] rem_cnt;
  logic [FW-1:0]    flush_cnt;
  logic             sop_pend;
  logic             primed;
  tag_t             dec_tag;
  tag_t             iss_tag;
  tag_t             push_tag;
  tag_t             head;
  tag_t             tag_pipe [DEC_LAT];
  logic             iss_valid;
  logic             iss_from_s;
  logic             start_acc;
  logic             data_hs;
  logic             done_set;

  assign head     = tag_pipe[DEC_LAT-1];
  assign out_keep = head.valid & head.keep;
  assign out_sop  = head.valid & head.sop;
  assign out_eop  = head.valid & head.eop;

  // The stage swallows its very first block after reset, so that block's
  // entry enters the pipe invalid and never claims a coefficient slot.
  always_comb begin
    push_tag       = dec_tag;
    push_tag.valid = dec_tag.valid & primed;
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state, upstream ready and the block to issue this cycle.
  always_comb begin
    state_nxt  = state;
    s_ready    = 1'b0;
    iss_valid  = 1'b0;
    iss_from_s = 1'b0;
    iss_tag    = '0;
    start_acc  = 1'b0;
    data_hs    = 1'b0;
    done_set   = 1'b0;
    case (state)
      IDLE: begin
        if (start && (cfg_num_blocks != '0)) begin
          start_acc = 1'b1;
          state_nxt = PRIME;
        end
      end
      PRIME: begin
        iss_valid     = 1'b1;
        iss_tag.valid = 1'b1;
        state_nxt     = DATA;
      end
      DATA: begin
        s_ready = 1'b1;
        if (s_valid) begin
          data_hs       = 1'b1;
          iss_valid     = 1'b1;
          iss_from_s    = 1'b1;
          iss_tag.valid = 1'b1;
          iss_tag.keep  = 1'b1;
          iss_tag.sop   = sop_pend;
          if (rem_cnt == CNT_W'(1)) state_nxt = FLUSH;
        end
      end
      FLUSH: begin
        iss_valid     = 1'b1;
        iss_tag.valid = 1'b1;
        iss_tag.keep  = 1'b1;
        if (flush_cnt == FW'(FLUSH_BLOCKS - 1)) begin
          iss_tag.eop = 1'b1;
          state_nxt   = DRAIN;
        end
      end
      DRAIN: begin
        // Stay here through the done cycle so a start there is ignored.
        if (done)          state_nxt = IDLE;
        else if (head.eop) done_set  = 1'b1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Frame counters, registered issue path, tag pipe and status flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rem_cnt   <= '0;
      flush_cnt <= '0;
      sop_pend  <= 1'b0;
      primed    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      dec_valid <= 1'b0;
      dec_data  <= '0;
      dec_tag   <= '0;
      for (int unsigned i = 0; i < DEC_LAT; i++) tag_pipe[i] <= '0;
    end else begin
      done <= done_set;
      if (start_acc) begin
        rem_cnt   <= cfg_num_blocks;
        sop_pend  <= 1'b1;
        flush_cnt <= '0;
        busy      <= 1'b1;
      end
      if (done_set) busy <= 1'b0;
      if (data_hs) begin
        rem_cnt  <= rem_cnt - CNT_W'(1);
        sop_pend <= 1'b0;
      end
      if (state == FLUSH) flush_cnt <= flush_cnt + FW'(1);
      dec_valid <= iss_valid;
      dec_data  <= iss_from_s ? s_data : '0;
      dec_tag   <= iss_tag;
      if (dec_valid) primed <= 1'b1;
      tag_pipe[0] <= push_tag;
      for (int unsigned i = 1; i < DEC_LAT; i++) tag_pipe[i] <= tag_pipe[i-1];
      if (head.valid != dec_dout_valid) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_decompose_frame_ctrl.sv
// Scoreboard bench for decompose_frame_ctrl: a behavioural decomposition-stage
// model drives dec_dout_valid, expected blocks and coefficient tags are queued
// per frame, and a negedge monitor pops and compares.
module tb_decompose_frame_ctrl;

  localparam int DW  = 16;
  localparam int NL  = 16;
  localparam int CW  = 16;
  localparam int FB  = 1;
  localparam int LAT = 3;
  localparam int BW  = NL * DW;

  logic          clk;
  logic          rst_n;
  logic          start;
  logic [CW-1:0] cfg_num_blocks;
  logic          s_valid;
  logic          s_ready;
  logic [BW-1:0] s_data;
  logic          dec_valid;
  logic [BW-1:0] dec_data;
  logic          dec_dout_valid;
  logic          out_keep;
  logic          out_sop;
  logic          out_eop;
  logic          busy;
  logic          done;
  logic          err;

  decompose_frame_ctrl #(
    .DATA_WIDTH  (DW),
    .NUM_LANES   (NL),
    .CNT_W       (CW),
    .FLUSH_BLOCKS(FB),
    .DEC_LAT     (LAT)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .start         (start),
    .cfg_num_blocks(cfg_num_blocks),
    .s_valid       (s_valid),
    .s_ready       (s_ready),
    .s_data        (s_data),
    .dec_valid     (dec_valid),
    .dec_data      (dec_data),
    .dec_dout_valid(dec_dout_valid),
    .out_keep      (out_keep),
    .out_sop       (out_sop),
    .out_eop       (out_eop),
    .busy          (busy),
    .done          (done),
    .err           (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h required %0h", name, act, exp);
    end
  endtask

  task automatic fail_unexpected(input string name);
    checks++;
    errors++;
    $display("FAIL %s: got an output, required none", name);
  endtask

  // Decomposition stage model: 3-cycle latency, first block after reset lost.
  logic [LAT-1:0] dv_pipe;
  logic           stage_primed;
  logic           inj_req;
  logic           inj_done;
  logic           inj;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dv_pipe      <= '0;
      stage_primed <= 1'b0;
    end else begin
      dv_pipe <= {dv_pipe[LAT-2:0], dec_valid & stage_primed};
      if (dec_valid) stage_primed <= 1'b1;
    end
  end

  // One-shot fault: output valid raised one cycle before the real one.
  assign inj = inj_req & ~inj_done & dv_pipe[LAT-2] & ~dv_pipe[LAT-1];
  assign dec_dout_valid = dv_pipe[LAT-1] | inj;
  always @(posedge clk) inj_done <= inj_req & (inj_done | inj);

  // Scoreboard queues filled by the driver.
  logic [BW-1:0] exp_data_q [$];
  logic [2:0]    exp_coef_q [$];
  bit            model_primed;

  // Monitor: compare issued blocks, coefficient tags, done and err.
  logic err_exp;
  logic done_exp;
  always @(negedge clk or negedge rst_n) begin
    logic [2:0] e;
    logic       done_nxt;
    if (!rst_n) begin
      exp_data_q.delete();
      exp_coef_q.delete();
      err_exp  = 1'b0;
      done_exp = 1'b0;
    end else begin
      done_nxt = 1'b0;
      if (dec_valid) begin
        if (exp_data_q.size() == 0) fail_unexpected("dec_data_extra");
        else chk("dec_data", dec_data, exp_data_q.pop_front());
      end
      if (dec_dout_valid && !inj) begin
        if (exp_coef_q.size() == 0) fail_unexpected("coef_extra");
        else begin
          e = exp_coef_q.pop_front();
          chk("coef_tags", {out_keep, out_sop, out_eop}, e);
          done_nxt = e[0];
        end
      end else if (!inj) begin
        chk("coef_idle", {out_keep, out_sop, out_eop}, 0);
      end
      chk("done", done, done_exp);
      done_exp = done_nxt;
      chk("err", err, err_exp);
      if (inj) err_exp = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [BW-1:0] rand_block();
    logic [BW-1:0] d;
    for (int j = 0; j < BW / 32; j++) d[j*32 +: 32] = $urandom;
    return d;
  endfunction

  task automatic check_all_zero(input string name);
    chk(name, {s_ready, dec_valid, out_keep, out_sop, out_eop, busy, done, err}, 0);
    chk({name, "_dec_data"}, dec_data, 0);
  endtask

  // Issue start and queue the frame's expected coefficient tags.
  task automatic start_frame(input int n);
    start          = 1'b1;
    cfg_num_blocks = CW'(n);
    tick();
    start = 1'b0;
    exp_data_q.push_back('0);
    if (model_primed) exp_coef_q.push_back(3'b000);
    model_primed = 1'b1;
    for (int i = 0; i < n; i++) exp_coef_q.push_back({1'b1, (i == 0), 1'b0});
    for (int i = 0; i < FB; i++) exp_coef_q.push_back({1'b1, 1'b0, (i == FB - 1)});
    chk("busy_after_start", busy, 1);
    chk("s_ready_prime", s_ready, 0);
    tick();
  endtask

  // Feed n blocks; mode 0 = always valid, 1 = fixed pattern, 2 = random.
  task automatic run_data(input int n, input int mode, input bit mid_start);
    bit pat [6] = '{1, 0, 0, 1, 0, 1};
    int hs = 0;
    int cyc = 0;
    bit sv;
    while (hs < n && cyc < 200) begin
      sv = (mode == 0) ? 1'b1 : (mode == 1) ? pat[cyc % 6] : 1'($urandom_range(0, 1));
      s_valid = sv;
      s_data  = rand_block();
      if (mid_start && cyc == 1) begin
        start          = 1'b1;
        cfg_num_blocks = CW'(7);
      end else begin
        start = 1'b0;
      end
      chk("s_ready_data", s_ready, 1);
      @(posedge clk);
      if (sv) begin
        exp_data_q.push_back(s_data);
        hs++;
      end
      #1;
      cyc++;
    end
    s_valid = 1'b0;
    start   = 1'b0;
    for (int i = 0; i < FB; i++) exp_data_q.push_back('0);
    chk("s_ready_after_data", s_ready, 0);
  endtask

  task automatic wait_done(input bit start_in_done);
    bit got = 1'b0;
    for (int c = 0; c < 40 && !got; c++) begin
      tick();
      if (done) got = 1'b1;
    end
    chk("done_seen", done, 1);
    if (start_in_done) begin
      start          = 1'b1;
      cfg_num_blocks = CW'(3);
    end
    tick();
    start = 1'b0;
    chk("busy_after_done", busy, 0);
    chk("done_single", done, 0);
    chk("data_q_drained", exp_data_q.size(), 0);
    chk("coef_q_drained", exp_coef_q.size(), 0);
  endtask

  task automatic frame(input int n, input int mode, input bit mid_start, input bit start_in_done);
    start_frame(n);
    run_data(n, mode, mid_start);
    wait_done(start_in_done);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst_n          = 1'b0;
    start          = 1'b0;
    cfg_num_blocks = '0;
    s_valid        = 1'b0;
    s_data         = '0;
    inj_req        = 1'b0;
    model_primed   = 1'b0;
    repeat (3) tick();
    check_all_zero("reset_state");
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Zero-length start in IDLE is ignored.
    start          = 1'b1;
    cfg_num_blocks = '0;
    tick();
    start = 1'b0;
    chk("zero_start_busy", busy, 0);
    tick();
    chk("zero_start_busy_later", busy, 0);

    frame(4, 0, 1'b0, 1'b1);
    frame(2, 0, 1'b0, 1'b0);
    frame(3, 1, 1'b0, 1'b0);
    frame(5, 2, 1'b1, 1'b0);
    for (int f = 0; f < 4; f++) frame(int'($urandom_range(1, 6)), 2, 1'b0, 1'b0);

    // Early output valid: err must set and stay set.
    inj_req = 1'b1;
    frame(2, 0, 1'b0, 1'b0);
    inj_req = 1'b0;
    chk("err_set", err, 1);
    frame(1, 0, 1'b0, 1'b0);
    chk("err_sticky", err, 1);

    // Reset in the middle of DATA.
    start_frame(5);
    s_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      s_data = rand_block();
      @(posedge clk);
      exp_data_q.push_back(s_data);
      #1;
    end
    #2;
    rst_n        = 1'b0;
    s_valid      = 1'b0;
    model_primed = 1'b0;
    #1;
    check_all_zero("async_reset");
    repeat (2) tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    frame(1, 0, 1'b0, 1'b0);
    chk("err_after_reset", err, 0);

    repeat (3) tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
